// File: rtl/bpu_pkg.sv
// Shared definitions for the BTB/RAS branch predictor.
//   - Branch-type encodings used on upd_type and stored per BTB entry.
//   - Field layout of the registered prediction bus sent to decode:
//       {hit, taken, is_cond, ctr[CTR_W-1:0], target[31:0]}
//   - Direction-counter helpers, written for the widest counter (4 bits);
//     callers pass the live counter width and truncate the result.
package bpu_pkg;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JUMP = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_type_e;

    localparam int PRED_TGT_W   = 32;
    localparam int PRED_TGT_LSB = 0;
    localparam int PRED_CTR_LSB = PRED_TGT_W;
    localparam int CTR_MAX_W    = 4;

    function automatic int pred_bus_w(input int ctr_w);
        return 3 + ctr_w + PRED_TGT_W;
    endfunction

    function automatic int pred_cond_bit(input int ctr_w);
        return PRED_CTR_LSB + ctr_w;
    endfunction

    function automatic int pred_taken_bit(input int ctr_w);
        return PRED_CTR_LSB + ctr_w + 1;
    endfunction

    function automatic int pred_hit_bit(input int ctr_w);
        return PRED_CTR_LSB + ctr_w + 2;
    endfunction

    function automatic logic [CTR_MAX_W-1:0] ctr_sat_inc(input logic [CTR_MAX_W-1:0] c,
                                                         input int ctr_w);
        logic [CTR_MAX_W-1:0] top;
        top = CTR_MAX_W'((1 << ctr_w) - 1);
        return (c >= top) ? top : c + 4'd1;
    endfunction

    function automatic logic [CTR_MAX_W-1:0] ctr_sat_dec(input logic [CTR_MAX_W-1:0] c);
        return (c == '0) ? '0 : c - 4'd1;
    endfunction

    // Weakly-taken initial value: only the MSB of the live counter set.
    function automatic logic [CTR_MAX_W-1:0] ctr_weak_taken(input int ctr_w);
        return CTR_MAX_W'(1 << (ctr_w - 1));
    endfunction

endpackage

// File: rtl/bpu_ras.sv
// Non-speculative return-address stack (built only with BPU_RAS_EN).
//   clk, resetn   : clock, synchronous active-low reset of pointer/count
//   push/push_addr: push a return address (wraps over the oldest when full)
//   pop           : pop the top entry (ignored when empty)
//   top_addr      : top of stack as it will be after this cycle's push/pop
//   nonempty      : stack holds at least one entry after this cycle's push/pop
// push and pop are never asserted together (one resolved branch per cycle).
module bpu_ras
    import bpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  logic [31:0] push_addr,
    input  logic        pop,
    output logic [31:0] top_addr,
    output logic        nonempty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      stack_mem [DEPTH];
    logic [PTR_W-1:0] ptr_q;    // next free slot; top lives at ptr_q-1
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            ptr_q <= ptr_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push) begin
            stack_mem[ptr_q] <= push_addr;
        end
    end

    // Expose the post-operation top so a lookup in the same cycle as the
    // resolving call/return already sees its effect.
    always_comb begin
        top_addr = stack_mem[ptr_q - PTR_W'(1)];
        nonempty = (cnt_q != '0);
        if (push) begin
            top_addr = push_addr;
            nonempty = 1'b1;
        end else if (pop) begin
            top_addr = stack_mem[ptr_q - PTR_W'(2)];
            nonempty = (cnt_q > CNT_W'(1));
        end
    end

endmodule

// File: rtl/bpu_btb_ras.sv
// Branch target buffer with per-entry saturating direction counters and an
// optional return-address stack (enable with macro BPU_RAS_EN).
//   clk, resetn             : clock, synchronous active-low reset
//   fs_pc, fs_valid         : fetch-stage lookup address and qualifier
//   ds_allowin, flush       : decode handshake / pipeline flush for ds_pred_bus
//   upd_valid, upd_pc,      : branch resolution from execute; captured into
//   upd_type, upd_taken,      the update stage every cycle and written into
//   upd_target                the table on the following edge
//   pred_hit/taken/target   : combinational prediction for fs_pc
//   ds_pred_bus             : registered {hit, taken, is_cond, ctr, target}
module bpu_btb_ras
    import bpu_pkg::*;
#(
    parameter int ENTRIES   = 256,
    parameter int TAG_W     = 22,
    parameter int CTR_W     = 2,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       fs_pc,
    input  logic              fs_valid,
    input  logic              ds_allowin,
    input  logic              flush,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic [1:0]        upd_type,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic [CTR_W+34:0] ds_pred_bus
);

    localparam int IDX_W = $clog2(ENTRIES);

    if (ENTRIES < 16 || ENTRIES > 1024 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("ENTRIES must be a power of two in 16..1024");
    end
    if (IDX_W + TAG_W + 2 > 32) begin : g_bad_tag
        $error("IDX_W + TAG_W + 2 exceeds 32");
    end
    if (CTR_W < 1 || CTR_W > CTR_MAX_W) begin : g_bad_ctr
        $error("CTR_W must be 1..4");
    end
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras
        $error("RAS_DEPTH must be a power of two >= 2");
    end

    function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[IDX_W+TAG_W+1:IDX_W+2];
    endfunction

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_mem  [ENTRIES];
    logic [CTR_W-1:0]   ctr_mem  [ENTRIES];
    logic [31:0]        tgt_mem  [ENTRIES];
    logic [1:0]         type_mem [ENTRIES];

    // Low PC bits are never part of index/tag; fold them so nothing dangles.
    logic unused_upd_pc;
    assign unused_upd_pc = ^upd_pc;

    // ---- stage U: resolved branch captured, write decided next cycle ----
    logic        vld_p1;
    logic [31:0] upd_pc_p1;
    logic [31:0] upd_target_p1;
    logic [1:0]  upd_type_p1;
    logic        upd_taken_p1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= upd_valid;
        end
    end

    always_ff @(posedge clk) begin
        upd_pc_p1     <= upd_pc;
        upd_target_p1 <= upd_target;
        upd_type_p1   <= upd_type;
        upd_taken_p1  <= upd_taken;
    end

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             u_we;
    logic [1:0]       u_type_eff;
    logic [TAG_W-1:0] w_tag;
    logic [CTR_W-1:0] w_ctr;
    logic [31:0]      w_tgt;
    logic [1:0]       w_type;

    assign u_idx = pc_idx(upd_pc_p1);
    assign u_tag = pc_tag(upd_pc_p1);
    assign u_hit = valid_q[u_idx] && (tag_mem[u_idx] == u_tag);
    // Only a taken miss allocates; a not-taken miss leaves the entry alone.
    assign u_we  = vld_p1 && (u_hit || upd_taken_p1);
    // A not-taken jump/call/return trains like a conditional branch.
    assign u_type_eff = upd_taken_p1 ? upd_type_p1 : BR_COND;

    always_comb begin
        w_tag  = u_tag;
        w_ctr  = ctr_mem[u_idx];
        w_tgt  = tgt_mem[u_idx];
        w_type = type_mem[u_idx];
        if (u_hit) begin
            if (upd_taken_p1) begin
                w_ctr  = CTR_W'(ctr_sat_inc(CTR_MAX_W'(ctr_mem[u_idx]), CTR_W));
                w_tgt  = upd_target_p1;
                w_type = u_type_eff;
            end else begin
                w_ctr = CTR_W'(ctr_sat_dec(CTR_MAX_W'(ctr_mem[u_idx])));
            end
        end else begin
            w_ctr  = CTR_W'(ctr_weak_taken(CTR_W));
            w_tgt  = upd_target_p1;
            w_type = u_type_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (u_we) begin
            valid_q[u_idx] <= 1'b1;
        end
    end

    // Gated by resetn so an update in flight across reset leaves no trace.
    always_ff @(posedge clk) begin
        if (resetn && u_we) begin
            tag_mem[u_idx]  <= w_tag;
            ctr_mem[u_idx]  <= w_ctr;
            tgt_mem[u_idx]  <= w_tgt;
            type_mem[u_idx] <= w_type;
        end
    end

    // ---- return-address stack ----
    logic ras_push;
    logic ras_pop;
    assign ras_push = vld_p1 && upd_taken_p1 && (upd_type_p1 == BR_CALL);
    assign ras_pop  = vld_p1 && upd_taken_p1 && (upd_type_p1 == BR_RET);

`ifdef BPU_RAS_EN
    logic [31:0] ras_top;
    logic        ras_nonempty;
    logic [31:0] ras_push_addr;
    assign ras_push_addr = upd_pc_p1 + 32'd8;

    bpu_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .resetn    (resetn),
        .push      (ras_push),
        .push_addr (ras_push_addr),
        .pop       (ras_pop),
        .top_addr  (ras_top),
        .nonempty  (ras_nonempty)
    );
`else
    logic unused_ras;
    assign unused_ras = ras_push ^ ras_pop;
`endif

    // ---- stage F: combinational lookup with same-index bypass ----
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             byp;
    logic             e_valid;
    logic [TAG_W-1:0] e_tag;
    logic [CTR_W-1:0] e_ctr;
    logic [31:0]      e_tgt;
    logic [1:0]       e_type;
    logic             e_cond;
    logic [31:0]      hit_tgt;

    assign f_idx = pc_idx(fs_pc);
    assign f_tag = pc_tag(fs_pc);
    assign byp   = u_we && (u_idx == f_idx);

    always_comb begin
        e_valid = valid_q[f_idx];
        e_tag   = tag_mem[f_idx];
        e_ctr   = ctr_mem[f_idx];
        e_tgt   = tgt_mem[f_idx];
        e_type  = type_mem[f_idx];
        if (byp) begin
            e_valid = 1'b1;
            e_tag   = w_tag;
            e_ctr   = w_ctr;
            e_tgt   = w_tgt;
            e_type  = w_type;
        end
    end

    assign e_cond = (e_type == BR_COND);

    always_comb begin
        hit_tgt = e_tgt;
`ifdef BPU_RAS_EN
        if ((e_type == BR_RET) && ras_nonempty) begin
            hit_tgt = ras_top;
        end
`endif
    end

    always_comb begin
        pred_hit    = fs_valid && e_valid && (e_tag == f_tag);
        pred_taken  = pred_hit && (e_cond ? e_ctr[CTR_W-1] : 1'b1);
        pred_target = pred_taken ? hit_tgt : fs_pc + 32'd8;
    end

    // ---- stage D: registered prediction toward decode ----
    logic [CTR_W+34:0] bus_d;

    always_comb begin
        bus_d = '0;
        bus_d[PRED_TGT_LSB +: PRED_TGT_W] = pred_target;
        bus_d[PRED_CTR_LSB +: CTR_W]      = pred_hit ? e_ctr : '0;
        bus_d[pred_cond_bit(CTR_W)]       = pred_hit && e_cond;
        bus_d[pred_taken_bit(CTR_W)]      = pred_taken;
        bus_d[pred_hit_bit(CTR_W)]        = pred_hit;
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            ds_pred_bus <= '0;
        end else if (ds_allowin) begin
            ds_pred_bus <= bus_d;
        end
    end

endmodule

// File: tb/tb_bpu_btb_ras.sv
module tb_bpu_btb_ras;
    import bpu_pkg::*;

    localparam int ENTRIES   = 256;
    localparam int TAG_W     = 22;
    localparam int CTR_W     = 2;
    localparam int RAS_DEPTH = 8;
    localparam int IDX_W     = 8;
    localparam int BUS_W     = 3 + CTR_W + 32;

    logic             clk = 1'b0;
    logic             resetn;
    logic [31:0]      fs_pc;
    logic             fs_valid;
    logic             ds_allowin;
    logic             flush;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [1:0]       upd_type;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic             pred_hit;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic [BUS_W-1:0] ds_pred_bus;

    always #5 clk = ~clk;

    bpu_btb_ras #(
        .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn), .fs_pc(fs_pc), .fs_valid(fs_valid),
        .ds_allowin(ds_allowin), .flush(flush), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_type(upd_type), .upd_taken(upd_taken),
        .upd_target(upd_target), .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_target(pred_target), .ds_pred_bus(ds_pred_bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // An update becomes visible to lookups from the edge that captures it.
    bit          m_valid [ENTRIES];
    logic [TAG_W-1:0] m_tag [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    logic [1:0]  m_type  [ENTRIES];
    logic [31:0] m_ras   [$];

    function automatic void model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_ras.delete();
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, input bit v,
                                         output bit hit, output bit taken, output bit cond,
                                         output int ctr, output logic [31:0] tgt);
        int i;
        logic [TAG_W-1:0] t;
        i = int'((pc >> 2) % ENTRIES);
        t = TAG_W'(pc >> (IDX_W + 2));
        hit   = v && m_valid[i] && (m_tag[i] == t);
        cond  = hit && (m_type[i] == BR_COND);
        ctr   = hit ? m_ctr[i] : 0;
        taken = hit && (!cond || m_ctr[i] >= (1 << (CTR_W - 1)));
        tgt   = pc + 32'd8;
        if (taken) begin
            tgt = m_tgt[i];
`ifdef BPU_RAS_EN
            if (m_type[i] == BR_RET && m_ras.size() > 0) tgt = m_ras[$];
`endif
        end
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic [1:0] ty,
                                         input bit tk, input logic [31:0] tg);
        int i;
        logic [TAG_W-1:0] t;
        bit hit;
        logic [1:0] ety;
        i   = int'((pc >> 2) % ENTRIES);
        t   = TAG_W'(pc >> (IDX_W + 2));
        hit = m_valid[i] && (m_tag[i] == t);
        ety = tk ? ty : BR_COND;
        if (hit) begin
            if (tk) begin
                if (m_ctr[i] < (1 << CTR_W) - 1) m_ctr[i] = m_ctr[i] + 1;
                m_tgt[i]  = tg;
                m_type[i] = ety;
            end else if (m_ctr[i] > 0) begin
                m_ctr[i] = m_ctr[i] - 1;
            end
        end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
            m_ctr[i]   = 1 << (CTR_W - 1);
            m_tgt[i]   = tg;
            m_type[i]  = ety;
        end
`ifdef BPU_RAS_EN
        if (tk && ty == BR_CALL) begin
            m_ras.push_back(pc + 32'd8);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end else if (tk && ty == BR_RET && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
        end
`endif
    endfunction

    // ---------------- helpers ----------------
    task automatic upd_op(input logic [31:0] pc, input logic [1:0] ty, input bit tk,
                          input logic [31:0] tg);
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = pc; upd_type = ty; upd_taken = tk; upd_target = tg;
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h8000_0000 | (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 1)) << 10);
    endfunction

    typedef struct {
        bit          uv;
        logic [31:0] upc;
        logic [1:0]  utype;
        bit          utaken;
        logic [31:0] utgt;
        logic [31:0] lpc;
        bit          ehit;
        bit          etaken;
        bit          econd;
        logic [1:0]  ectr;
        logic [31:0] etgt;
    } vec_t;

    vec_t vecs[12];
    logic [BUS_W-1:0] exp_bus;
    logic [BUS_W-1:0] cur_bus;
    bit   mh, mt, mc;
    int   mctr;
    logic [31:0] mtgt;

    initial begin
        vecs[0]  = '{1, 32'h8000_1000, BR_COND, 1, 32'h8000_2000, 32'h8000_1000, 1, 1, 1, 2'b10, 32'h8000_2000};
        vecs[1]  = '{1, 32'h8000_1000, BR_COND, 0, 32'h8000_2000, 32'h8000_1000, 1, 0, 1, 2'b01, 32'h8000_1008};
        vecs[2]  = '{1, 32'h8000_1000, BR_COND, 0, 32'h8000_2000, 32'h8000_1000, 1, 0, 1, 2'b00, 32'h8000_1008};
        vecs[3]  = '{1, 32'h8000_1000, BR_COND, 0, 32'h8000_2000, 32'h8000_1000, 1, 0, 1, 2'b00, 32'h8000_1008};
        vecs[4]  = '{1, 32'h8000_1000, BR_COND, 1, 32'h8000_2000, 32'h8000_1000, 1, 0, 1, 2'b01, 32'h8000_1008};
        vecs[5]  = '{1, 32'h8000_1000, BR_COND, 1, 32'h8000_2000, 32'h8000_1000, 1, 1, 1, 2'b10, 32'h8000_2000};
        vecs[6]  = '{1, 32'h8000_1000, BR_COND, 1, 32'h8000_2000, 32'h8000_1000, 1, 1, 1, 2'b11, 32'h8000_2000};
        vecs[7]  = '{1, 32'h8000_1000, BR_COND, 1, 32'h8000_2000, 32'h8000_1000, 1, 1, 1, 2'b11, 32'h8000_2000};
        vecs[8]  = '{1, 32'h9000_1000, BR_COND, 1, 32'h9000_3000, 32'h8000_1000, 0, 0, 0, 2'b00, 32'h8000_1008};
        vecs[9]  = '{0, 32'h0,         BR_COND, 0, 32'h0,         32'h9000_1000, 1, 1, 1, 2'b10, 32'h9000_3000};
        vecs[10] = '{1, 32'h9000_1000, BR_JUMP, 0, 32'h9000_7000, 32'h9000_1000, 1, 0, 1, 2'b01, 32'h9000_1008};
        vecs[11] = '{1, 32'h8000_4010, BR_JUMP, 1, 32'h8000_0040, 32'h8000_4010, 1, 1, 0, 2'b10, 32'h8000_0040};

        resetn = 1'b0; fs_pc = 32'hBFC0_0000; fs_valid = 1'b1; ds_allowin = 1'b1; flush = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_type = BR_COND; upd_taken = 1'b0; upd_target = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus", 64'(ds_pred_bus), 64'd0);
        check("rst_hit", 64'(pred_hit), 64'd0);
        check("rst_taken", 64'(pred_taken), 64'd0);
        check("rst_target", 64'(pred_target), 64'hBFC0_0008);
        @(negedge clk);
        resetn = 1'b1;

        // Training table: update, one write edge, then check lookup and bus
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            upd_valid = vecs[v].uv; upd_pc = vecs[v].upc; upd_type = vecs[v].utype;
            upd_taken = vecs[v].utaken; upd_target = vecs[v].utgt; fs_pc = vecs[v].lpc;
            @(posedge clk);
            #1 upd_valid = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_hit", v), 64'(pred_hit), 64'(vecs[v].ehit));
            check($sformatf("vec%0d_taken", v), 64'(pred_taken), 64'(vecs[v].etaken));
            check($sformatf("vec%0d_target", v), 64'(pred_target), 64'(vecs[v].etgt));
            check($sformatf("vec%0d_bus", v), 64'(ds_pred_bus),
                  64'({vecs[v].ehit, vecs[v].etaken, vecs[v].econd, vecs[v].ectr, vecs[v].etgt}));
        end

        // Bypass: lookup at index 0 while U holds a write to index 0
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h8000_0000; upd_type = BR_JUMP; upd_taken = 1'b1;
        upd_target = 32'h8000_0400; fs_pc = 32'h8000_0000;
        #1 check("byp_before_hit", 64'(pred_hit), 64'd0);
        @(posedge clk);
        #1 upd_valid = 1'b0;
        check("byp_hit", 64'(pred_hit), 64'd1);
        check("byp_target", 64'(pred_target), 64'h8000_0400);

        // flush beats ds_allowin; ds_allowin=0 holds
        @(negedge clk);
        flush = 1'b1; ds_allowin = 1'b1;
        @(posedge clk);
        #1 check("flush_bus", 64'(ds_pred_bus), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        #1 check("capture_bus", 64'(ds_pred_bus), 64'({1'b1, 1'b1, 1'b0, 2'b10, 32'h8000_0400}));
        @(negedge clk);
        ds_allowin = 1'b0; fs_pc = 32'h8000_1000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 check($sformatf("hold_bus%0d", k), 64'(ds_pred_bus),
                     64'({1'b1, 1'b1, 1'b0, 2'b10, 32'h8000_0400}));
        end
        @(negedge clk);
        ds_allowin = 1'b1;

`ifdef BPU_RAS_EN
        upd_op(32'h8000_0300, BR_RET, 1'b1, 32'h8000_0F00);
        upd_op(32'h8000_0100, BR_CALL, 1'b1, 32'h8000_0800);
        @(negedge clk);
        fs_pc = 32'h8000_0300;
        #1 check("ras_ret_target", 64'(pred_target), 64'h8000_0108);
        upd_op(32'h8000_0300, BR_RET, 1'b1, 32'h8000_0F00);
        @(negedge clk);
        #1 check("ras_empty_target", 64'(pred_target), 64'h8000_0F00);
        for (int k = 0; k < 9; k++) upd_op(32'h8000_0100 + 32'(16 * k), BR_CALL, 1'b1, 32'h8000_0800);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            fs_pc = 32'h8000_0300;
            #1 check($sformatf("ras_pop%0d", k), 64'(pred_target),
                     (k < 8) ? 64'(32'h8000_0100 + 32'(16 * (8 - k)) + 32'd8) : 64'h8000_0F00);
            upd_op(32'h8000_0300, BR_RET, 1'b1, 32'h8000_0F00);
        end
`endif

        // Reset with an update pending in U discards it
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h8000_0200; upd_type = BR_COND; upd_taken = 1'b1;
        upd_target = 32'h8000_0A00; fs_pc = 32'h8000_0200;
        @(posedge clk);
        #1 upd_valid = 1'b0; resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1 check("rst_pending_hit", 64'(pred_hit), 64'd0);
        @(posedge clk);
        #1 check("rst_pending_hit2", 64'(pred_hit), 64'd0);
        check("rst_pending_bus", 64'(ds_pred_bus), 64'({1'b0, 1'b0, 1'b0, 2'b00, 32'h8000_0208}));
        exp_bus = ds_pred_bus;
        model_reset();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            fs_pc      = rand_pc();
            fs_valid   = ($urandom_range(0, 3) != 0);
            ds_allowin = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 9) == 0);
            upd_valid  = ($urandom_range(0, 2) != 0);
            upd_pc     = rand_pc();
            upd_type   = 2'($urandom_range(0, 3));
            upd_taken  = ($urandom_range(0, 2) != 0);
            upd_target = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
            #1;
            model_lookup(fs_pc, fs_valid, mh, mt, mc, mctr, mtgt);
            check("rnd_hit", 64'(pred_hit), 64'(mh));
            check("rnd_taken", 64'(pred_taken), 64'(mt));
            check("rnd_target", 64'(pred_target), 64'(mtgt));
            cur_bus = {mh, mt, mc, CTR_W'(mctr), mtgt};
            if (flush) exp_bus = '0;
            else if (ds_allowin) exp_bus = cur_bus;
            @(posedge clk);
            #1;
            check("rnd_bus", 64'(ds_pred_bus), 64'(exp_bus));
            if (upd_valid) model_update(upd_pc, upd_type, upd_taken, upd_target);
            upd_valid = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
